// File: rtl/bbfifo_16x8_if.sv
// rtl/bbfifo_16x8_if.sv - data and status bundle between the FIFO and its producer/consumer
interface bbfifo_16x8_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] data_in;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_out;
    logic             data_present;
    logic             half_full;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, write, read,
        input  data_out, data_present, half_full, full, overflow, underflow
    );

    modport slave (
        input  data_in, write, read,
        output data_out, data_present, half_full, full, overflow, underflow
    );
endinterface

// File: rtl/bbfifo_16x8.sv
// rtl/bbfifo_16x8.sv - 16x8 first-word fall-through FIFO over 16x1 distributed RAM slices
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module bbfifo_16x8 #(
    parameter int WIDTH     = 8,
    parameter int HALF_MARK = 8
) (
    input  logic          clk,
    input  logic          reset,
    bbfifo_16x8_if.slave  bus
);
    localparam logic [4:0] HALF_CNT = 5'(HALF_MARK);
    localparam logic [4:0] FULL_CNT = 5'd16;

    logic [3:0]       wr_ptr;
    logic [3:0]       rd_ptr;
    logic [4:0]       count;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_word;

    // Accept decisions look only at the registered flags, never at pointer equality.
    assign wr_ok = bus.write & (~bus.full | bus.read);
    assign rd_ok = bus.read & bus.data_present;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
            count  <= 5'd0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 4'd1;
            if (rd_ok) rd_ptr <= rd_ptr + 4'd1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_slice
        logic [15:0] ram;

        always_ff @(posedge clk) begin
            if (wr_ok && !reset) ram[wr_ptr] <= bus.data_in[g];
        end

        assign rd_word[g] = ram[rd_ptr];
    end

    assign bus.data_out     = rd_word;
    assign bus.data_present = (count != 5'd0);
    assign bus.half_full    = (count >= HALF_CNT);
    assign bus.full         = (count == FULL_CNT);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.write && bus.full && !bus.read) overflow_q  <= 1'b1;
            if (bus.read && !bus.data_present)      underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_bbfifo_16x8.sv
// tb/tb_bbfifo_16x8.sv - vector table, corner sequences and random traffic against a queue model
module tb_bbfifo_16x8;
    logic clk = 1'b0;
    logic reset;

    bbfifo_16x8_if #(.WIDTH(8)) bus ();

    bbfifo_16x8 #(.WIDTH(8), .HALF_MARK(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       e_present;
        logic       e_half;
        logic       e_full;
        logic [7:0] e_dout;
    } vec_t;

    vec_t       vecs[11];
    logic [7:0] q[$];
    logic       m_ovf;
    logic       m_udf;
    int         checks = 0;
    int         errors = 0;

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic w, input logic r, input logic [7:0] d);
        int  n;
        bit  was_full;
        bit  was_empty;
        n = q.size();
        was_full  = (n == 16);
        was_empty = (n == 0);
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && was_full && !r) m_ovf = 1'b1;
            if (r && was_empty)      m_udf = 1'b1;
            if (r && !was_empty)            void'(q.pop_front());
            if (w && (!was_full || r))      q.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        check1({tag, ".present"}, bus.data_present, (n != 0));
        check1({tag, ".half"},    bus.half_full,    (n >= 8));
        check1({tag, ".full"},    bus.full,         (n == 16));
`ifdef FIFO_ERR_FLAGS_EN
        check1({tag, ".ovf"},     bus.overflow,     m_ovf);
        check1({tag, ".udf"},     bus.underflow,    m_udf);
`else
        check1({tag, ".ovf"},     bus.overflow,     1'b0);
        check1({tag, ".udf"},     bus.underflow,    1'b0);
`endif
        if (n != 0) check1({tag, ".dout"}, bus.data_out, q[0]);
    endtask

    task automatic step(input logic rst, input logic w, input logic r, input logic [7:0] d,
                        input string tag);
        reset       = rst;
        bus.write   = w;
        bus.read    = r;
        bus.data_in = d;
        @(posedge clk);
        model_step(rst, w, r, d);
        #1;
        reset     = 1'b0;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        check_model(tag);
    endtask

    initial begin
        logic [7:0] v;
        int         pw;
        int         pr;

        reset = 1'b1; bus.write = 1'b0; bus.read = 1'b0; bus.data_in = 8'h00;
        m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clk);

        //            rst   wr    rd    din    pres  half  full  dout
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b0, 8'h66};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din, $sformatf("vec%0d", i));
            check1($sformatf("vec%0d.tbl_present", i), bus.data_present, vecs[i].e_present);
            check1($sformatf("vec%0d.tbl_half", i),    bus.half_full,    vecs[i].e_half);
            check1($sformatf("vec%0d.tbl_full", i),    bus.full,         vecs[i].e_full);
            if (vecs[i].e_present)
                check1($sformatf("vec%0d.tbl_dout", i), bus.data_out, vecs[i].e_dout);
        end

        // Fill to 16, watch half/full thresholds, drop a 17th write, drain in order.
        step(1'b1, 1'b0, 1'b0, 8'h00, "fill.rst");
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i), $sformatf("fill.w%0d", i));
            check1($sformatf("fill.half%0d", i), bus.half_full, (i >= 7));
            check1($sformatf("fill.full%0d", i), bus.full,      (i == 15));
        end
        step(1'b0, 1'b1, 1'b0, 8'hFF, "fill.drop");
        check1("fill.drop_full", bus.full, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check1($sformatf("drain.d%0d", i), bus.data_out, 8'(i));
            step(1'b0, 1'b0, 1'b1, 8'h00, $sformatf("drain.r%0d", i));
        end
        check1("drain.empty", bus.data_present, 1'b0);

        // Full with simultaneous read and write: 77 must come out last.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i), "refill");
        step(1'b0, 1'b1, 1'b1, 8'h77, "full_rw");
        check1("full_rw.full", bus.full, 1'b1);
        for (int i = 0; i < 16; i++) begin
            v = (i == 15) ? 8'h77 : 8'(8'h81 + i);
            check1($sformatf("full_rw.d%0d", i), bus.data_out, v);
            step(1'b0, 1'b0, 1'b1, 8'h00, "full_rw.rd");
        end

        // Pointer wrap across 15 -> 0.
        step(1'b1, 1'b0, 1'b0, 8'h00, "wrap.rst");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 8'(i), "wrap.w");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 8'h00, "wrap.r");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), "wrap.w2");
        for (int i = 0; i < 10; i++) begin
            check1($sformatf("wrap.d%0d", i), bus.data_out, 8'(8'h20 + i));
            step(1'b0, 1'b0, 1'b1, 8'h00, "wrap.r2");
        end
        check1("wrap.empty", bus.data_present, 1'b0);

        // Random traffic in phases that favour filling, draining or balance.
        step(1'b1, 1'b0, 1'b0, 8'h00, "rnd.rst");
        for (int i = 0; i < 3000; i++) begin
            case ((i / 100) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 50; pr = 50; end
            endcase
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < pw),
                 ($urandom_range(0, 99) < pr),
                 8'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
